// File: rtl/inst_encoder.sv
// RV64I instruction encoder: packs fields and immediate into a 32-bit word, flags
// range/alignment/opcode errors, and queues results in a 2-entry in-order FIFO.
module inst_encoder #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [6:0]            req_opcode_i,
  input  logic [4:0]            req_rd_i,
  input  logic [4:0]            req_rs1_i,
  input  logic [4:0]            req_rs2_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [6:0]            req_funct7_i,
  input  logic [DATA_WIDTH-1:0] req_imm_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [31:0]           inst_o,
  output logic [1:0]            err_code_o,
  input  logic                  cnt_clr_i,
  output logic [15:0]           enc_cnt_o,
  output logic [15:0]           err_cnt_o
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [2:0] {FmtI, FmtS, FmtB, FmtJ, FmtU, FmtR, FmtBad} fmt_e;

  // True when bits [DATA_WIDTH-1:msb] are all equal, i.e. v is the sign extension of v[msb:0].
  function automatic logic fits_sext(input logic [DATA_WIDTH-1:0] v, input int unsigned msb);
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] ones;
    ones = '1;
    hi   = v >> msb;
    return (hi == '0) || (hi == (ones >> msb));
  endfunction

  fmt_e                  w_fmt;
  logic [31:0]           w_enc;
  logic                  w_range;
  logic                  w_mis;
  logic [1:0]            w_err;
  logic [31:0]           w_inst;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_imm;

  logic [31:0] r_inst [2];
  logic [1:0]  r_err  [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_cnt;
  logic [15:0] r_enc_cnt;
  logic [15:0] r_err_cnt;

  assign w_imm = req_imm_i;

  always_comb begin
    w_fmt = FmtBad;
    case (req_opcode_i)
      7'h13, 7'h1b, 7'h03, 7'h67: w_fmt = FmtI;
      7'h23:                      w_fmt = FmtS;
      7'h63:                      w_fmt = FmtB;
      7'h6f:                      w_fmt = FmtJ;
      7'h17, 7'h37:               w_fmt = FmtU;
      7'h33, 7'h3b:               w_fmt = FmtR;
      default:                    w_fmt = FmtBad;
    endcase
  end

  always_comb begin
    w_enc   = Nop;
    w_range = 1'b0;
    w_mis   = 1'b0;
    case (w_fmt)
      FmtI: begin
        w_enc   = {w_imm[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
        w_range = !fits_sext(w_imm, 11);
      end
      FmtS: begin
        w_enc   = {w_imm[11:5], req_rs2_i, req_rs1_i, req_funct3_i, w_imm[4:0], req_opcode_i};
        w_range = !fits_sext(w_imm, 11);
      end
      FmtB: begin
        w_enc   = {w_imm[12], w_imm[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                   w_imm[4:1], w_imm[11], req_opcode_i};
        w_range = !fits_sext(w_imm, 12);
        w_mis   = w_imm[0];
      end
      FmtJ: begin
        w_enc   = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], req_rd_i, req_opcode_i};
        w_range = !fits_sext(w_imm, 20);
        w_mis   = w_imm[0];
      end
      FmtU: begin
        w_enc   = {w_imm[31:12], req_rd_i, req_opcode_i};
        w_range = (w_imm[11:0] != 12'h000) || !fits_sext(w_imm, 31);
      end
      FmtR: begin
        w_enc = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_err = 2'd0;
    if (w_fmt == FmtBad) w_err = 2'd3;
    else if (w_mis)      w_err = 2'd2;
    else if (w_range)    w_err = 2'd1;
    w_inst = (w_err != 2'd0) ? Nop : w_enc;
  end

  // Ready depends only on registered occupancy, never on inst_ready_i.
  assign req_ready_o  = rst_n & (r_cnt != 2'd2);
  assign inst_valid_o = (r_cnt != 2'd0);
  assign inst_o       = inst_valid_o ? r_inst[r_rd_ptr] : 32'h0;
  assign err_code_o   = inst_valid_o ? r_err[r_rd_ptr] : 2'd0;
  assign w_push       = req_valid_i & req_ready_o;
  assign w_pop        = inst_valid_o & inst_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst[0] <= '0;
      r_inst[1] <= '0;
      r_err[0]  <= '0;
      r_err[1]  <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      if (w_push) begin
        r_inst[r_wr_ptr] <= w_inst;
        r_err[r_wr_ptr]  <= w_err;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_cnt <= 16'h0;
      r_err_cnt <= 16'h0;
    end else if (cnt_clr_i) begin
      r_enc_cnt <= 16'h0;
      r_err_cnt <= 16'h0;
    end else if (w_push) begin
      if (r_enc_cnt != 16'hffff) r_enc_cnt <= r_enc_cnt + 16'h1;
      if ((w_err != 2'd0) && (r_err_cnt != 16'hffff)) r_err_cnt <= r_err_cnt + 16'h1;
    end
  end

  assign enc_cnt_o = r_enc_cnt;
  assign err_cnt_o = r_err_cnt;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: encodings, errors, backpressure,
// counter saturation/clear and reset mid-operation.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [6:0]  req_opcode_i;
  logic [4:0]  req_rd_i;
  logic [4:0]  req_rs1_i;
  logic [4:0]  req_rs2_i;
  logic [2:0]  req_funct3_i;
  logic [6:0]  req_funct7_i;
  logic [63:0] req_imm_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [1:0]  err_code_o;
  logic        cnt_clr_i;
  logic [15:0] enc_cnt_o;
  logic [15:0] err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int enc_exp  = 0;
  int err_exp  = 0;

  always #5 clk = ~clk;

  inst_encoder #(.DATA_WIDTH(64)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_opcode_i (req_opcode_i),
    .req_rd_i     (req_rd_i),
    .req_rs1_i    (req_rs1_i),
    .req_rs2_i    (req_rs2_i),
    .req_funct3_i (req_funct3_i),
    .req_funct7_i (req_funct7_i),
    .req_imm_i    (req_imm_i),
    .inst_valid_o (inst_valid_o),
    .inst_ready_i (inst_ready_i),
    .inst_o       (inst_o),
    .err_code_o   (err_code_o),
    .cnt_clr_i    (cnt_clr_i),
    .enc_cnt_o    (enc_cnt_o),
    .err_cnt_o    (err_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] imm);
    req_opcode_i = op;
    req_rd_i     = rd;
    req_rs1_i    = rs1;
    req_rs2_i    = rs2;
    req_funct3_i = f3;
    req_funct7_i = f7;
    req_imm_i    = imm;
  endtask

  // Called at a negedge with an empty FIFO; checks 1-cycle latency, word, error and counters.
  task automatic enc_one(input string tag, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [63:0] imm,
                         input logic [31:0] exp_inst, input logic [1:0] exp_err);
    set_req(op, rd, rs1, rs2, f3, f7, imm);
    req_valid_i  = 1'b1;
    inst_ready_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    check_eq({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd1);
    check_eq({tag, "_inst"}, inst_o, exp_inst);
    check_eq({tag, "_err"}, {30'd0, err_code_o}, {30'd0, exp_err});
    enc_exp++;
    if (exp_err != 2'd0) err_exp++;
    check_eq({tag, "_enc_cnt"}, {16'd0, enc_cnt_o}, enc_exp);
    check_eq({tag, "_err_cnt"}, {16'd0, err_cnt_o}, err_exp);
    @(negedge clk);
    check_eq({tag, "_drained"}, {31'd0, inst_valid_o}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid_i  = 1'b0;
    inst_ready_i = 1'b1;
    cnt_clr_i    = 1'b0;
    set_req(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    #1;
    check_eq("rst_ready", {31'd0, req_ready_o}, 32'd0);
    check_eq("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    check_eq("rst_inst", inst_o, 32'd0);
    check_eq("rst_cnts", {enc_cnt_o, err_cnt_o}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);

    enc_one("addi_m1", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hffff_ffff_ffff_ffff,
            32'hfff0_0093, 2'd0);
    enc_one("sw",      7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 64'd8, 32'h0020_a423, 2'd0);
    enc_one("lui",     7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 64'h1234_5000, 32'h1234_52b7, 2'd0);
    enc_one("jal",     7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2, 32'h0020_00ef, 2'd0);
    enc_one("sub",     7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 64'd0, 32'h4020_81b3, 2'd0);
    enc_one("beq",     7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd8, 32'h0020_8463, 2'd0);
    enc_one("b_mis",   7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3, 32'h0000_0013, 2'd2);
    enc_one("i_rng",   7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048, 32'h0000_0013, 2'd1);
    enc_one("bad_op",  7'h7f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1, 32'h0000_0013, 2'd3);
    enc_one("u_rng",   7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h800, 32'h0000_0013, 2'd1);
    enc_one("j_prio",  7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'h10_0001, 32'h0000_0013, 2'd2);

    // Backpressure: three back-to-back requests against a stalled consumer.
    inst_ready_i = 1'b0;
    req_valid_i  = 1'b1;
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd1);
    @(negedge clk);
    check_eq("bp_ready1", {31'd0, req_ready_o}, 32'd1);
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2);
    @(negedge clk);
    check_eq("bp_ready2", {31'd0, req_ready_o}, 32'd0);
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd3);
    @(negedge clk);
    check_eq("bp_full", {31'd0, req_ready_o}, 32'd0);
    check_eq("bp_hold", inst_o, 32'h0010_0093);
    inst_ready_i = 1'b1;
    @(negedge clk);
    check_eq("bp_w1", inst_o, 32'h0020_0093);
    check_eq("bp_ready3", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    check_eq("bp_w2", inst_o, 32'h0030_0093);
    @(negedge clk);
    check_eq("bp_empty", {31'd0, inst_valid_o}, 32'd0);
    check_eq("bp_empty_inst", inst_o, 32'd0);
    enc_exp += 3;
    check_eq("bp_enc_cnt", {16'd0, enc_cnt_o}, enc_exp);

    // Saturation: clear, then 65537 errored accepts at full throughput.
    cnt_clr_i = 1'b1;
    @(negedge clk);
    cnt_clr_i = 1'b0;
    check_eq("clr_idle", {enc_cnt_o, err_cnt_o}, 32'd0);
    set_req(7'h7f, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    req_valid_i = 1'b1;
    repeat (65537) @(negedge clk);
    req_valid_i = 1'b0;
    check_eq("sat_enc", {16'd0, enc_cnt_o}, 32'h0000_ffff);
    check_eq("sat_err", {16'd0, err_cnt_o}, 32'h0000_ffff);
    @(negedge clk);
    set_req(7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    req_valid_i = 1'b1;
    cnt_clr_i   = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    cnt_clr_i   = 1'b0;
    check_eq("clr_win", {enc_cnt_o, err_cnt_o}, 32'd0);
    check_eq("clr_word", inst_o, 32'h0000_0013);
    @(negedge clk);
    check_eq("clr_hold", {enc_cnt_o, err_cnt_o}, 32'd0);

    // Reset with two entries queued.
    inst_ready_i = 1'b0;
    req_valid_i  = 1'b1;
    set_req(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5);
    @(negedge clk);
    @(negedge clk);
    req_valid_i = 1'b0;
    check_eq("mid_full", {31'd0, req_ready_o}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_valid", {31'd0, inst_valid_o}, 32'd0);
    check_eq("mid_inst", inst_o, 32'd0);
    check_eq("mid_ready", {31'd0, req_ready_o}, 32'd0);
    check_eq("mid_cnts", {enc_cnt_o, err_cnt_o}, 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    inst_ready_i = 1'b1;
    #1;
    check_eq("rel_ready", {31'd0, req_ready_o}, 32'd1);
    check_eq("rel_valid", {31'd0, inst_valid_o}, 32'd0);
    @(negedge clk);
    enc_exp = 0;
    err_exp = 0;
    enc_one("after_rst", 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 64'd8, 32'h0020_a423, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
